// File: rtl/bin2bcd_seq.sv
//------------------------------------------------------------------------------
// bin2bcd_seq
//
// Iterative (double-dabble) binary-to-BCD converter. One binary bit is shifted
// into the BCD field per clock, so a conversion of an IN_W-bit value takes
// IN_W cycles. The result is registered, saturated to DIGITS digits and handed
// to the multiplexed 7-segment display together with an overflow flag.
//
// Optional feature macro: BIN2BCD_BLANK_EN
//   When defined, a registered leading-zero blank mask is produced on 'blank'.
//   When undefined, the 'blank' port and its logic are absent.
//
// Parameters:
//   IN_W       width of the binary input
//   DIGITS     BCD digits presented on bcd_out
//   INT_DIGITS internal BCD digits (10**INT_DIGITS > 2**IN_W, >= DIGITS)
//
// Ports:
//   clk_50Mhz  in   system clock
//   rst        in   asynchronous reset, active-high
//   start      in   conversion request, sampled only while idle
//   bin_in     in   unsigned binary value, captured on the accepted start edge
//   busy       out  high while a conversion is in progress
//   done       out  one-cycle pulse, result outputs update in the same cycle
//   bcd_out    out  BCD result, units digit in [3:0]
//   overflow   out  result did not fit in DIGITS digits (bcd_out shows 9s)
//   blank      out  leading-zero blank mask (BIN2BCD_BLANK_EN only)
//------------------------------------------------------------------------------
module bin2bcd_seq #(
    parameter int IN_W       = 16,
    parameter int DIGITS     = 4,
    parameter int INT_DIGITS = 5
) (
    input  logic                  clk_50Mhz,
    input  logic                  rst,
    input  logic                  start,
    input  logic [IN_W-1:0]       bin_in,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic                  overflow
`ifdef BIN2BCD_BLANK_EN
    ,
    output logic [DIGITS-1:0]     blank
`endif
);

    localparam int BCD_W = 4 * INT_DIGITS;
    localparam int SR_W  = BCD_W + IN_W;
    localparam int OUT_W = 4 * DIGITS;
    localparam int CNT_W = (IN_W > 1) ? $clog2(IN_W) : 1;
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(IN_W - 1);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t             state_q,    state_d;
    logic [SR_W-1:0]    shiftReg_q, shiftReg_d;
    logic [CNT_W-1:0]   count_q,    count_d;
    logic               done_q,     done_d;
    logic [OUT_W-1:0]   bcdOut_q,   bcdOut_d;
    logic               overflow_q, overflow_d;

    logic [SR_W-1:0]    adjusted;
    logic [SR_W-1:0]    shifted;
    logic [BCD_W-1:0]   bcdFinal;
    logic [OUT_W-1:0]   bcdSat;
    logic               satOverflow;

`ifdef BIN2BCD_BLANK_EN
    logic [DIGITS-1:0]  blank_q, blank_d;
    logic [DIGITS-1:0]  blankNext;
    logic               zeroAbove;
`endif

    // One double-dabble step: every BCD digit that is 5 or more gets +3 so
    // that the following left shift carries correctly into the next decade.
    // A digit is at most 9 here, so the adjusted value never exceeds 4'hC.
    always_comb begin
        adjusted = shiftReg_q;
        for (int d = 0; d < INT_DIGITS; d++) begin
            if (shiftReg_q[IN_W + 4*d +: 4] >= 4'd5) begin
                adjusted[IN_W + 4*d +: 4] = shiftReg_q[IN_W + 4*d +: 4] + 4'd3;
            end
        end
        shifted = adjusted << 1;
    end

    // On the final iteration the upper field of the shifted register is the
    // complete internal BCD result.
    assign bcdFinal = shifted[SR_W-1:IN_W];

    // Saturation: any non-zero digit beyond the displayed ones means the value
    // cannot be shown, so the display gets all nines and the overflow flag.
    always_comb begin
        satOverflow = 1'b0;
        for (int d = DIGITS; d < INT_DIGITS; d++) begin
            if (bcdFinal[4*d +: 4] != 4'd0) begin
                satOverflow = 1'b1;
            end
        end
        bcdSat = satOverflow ? {DIGITS{4'h9}} : bcdFinal[OUT_W-1:0];
    end

`ifdef BIN2BCD_BLANK_EN
    // Leading-zero blanking, scanned from the most significant digit down.
    // Digit 0 is never blanked so a value of zero still shows a single "0".
    always_comb begin
        blankNext = '0;
        zeroAbove = 1'b1;
        for (int d = DIGITS - 1; d > 0; d--) begin
            zeroAbove    = zeroAbove & (bcdSat[4*d +: 4] == 4'd0);
            blankNext[d] = zeroAbove & ~satOverflow;
        end
    end
`endif

    // Next-state logic. IDLE waits for start and loads the shift register;
    // SHIFT runs one iteration per clock and publishes the result on the
    // edge that completes the last iteration, returning straight to IDLE so
    // a new start can be taken during the done cycle.
    always_comb begin
        state_d    = state_q;
        shiftReg_d = shiftReg_q;
        count_d    = count_q;
        done_d     = 1'b0;
        bcdOut_d   = bcdOut_q;
        overflow_d = overflow_q;
`ifdef BIN2BCD_BLANK_EN
        blank_d    = blank_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d    = SHIFT;
                    shiftReg_d = {{BCD_W{1'b0}}, bin_in};
                    count_d    = '0;
                end
            end
            SHIFT: begin
                shiftReg_d = shifted;
                count_d    = count_q + CNT_W'(1);
                if (count_q == LAST_ITER) begin
                    state_d    = IDLE;
                    done_d     = 1'b1;
                    bcdOut_d   = bcdSat;
                    overflow_d = satOverflow;
`ifdef BIN2BCD_BLANK_EN
                    blank_d    = blankNext;
`endif
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and result registers. Reset abandons any conversion in flight and
    // clears the published outputs immediately.
    always_ff @(posedge clk_50Mhz or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            shiftReg_q <= '0;
            count_q    <= '0;
            done_q     <= 1'b0;
            bcdOut_q   <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            shiftReg_q <= shiftReg_d;
            count_q    <= count_d;
            done_q     <= done_d;
            bcdOut_q   <= bcdOut_d;
            overflow_q <= overflow_d;
        end
    end

`ifdef BIN2BCD_BLANK_EN
    // Blank mask register, updated on the same edge as bcd_out.
    always_ff @(posedge clk_50Mhz or posedge rst) begin
        if (rst) begin
            blank_q <= '0;
        end else begin
            blank_q <= blank_d;
        end
    end

    assign blank = blank_q;
`endif

    assign busy     = (state_q == SHIFT);
    assign done     = done_q;
    assign bcd_out  = bcdOut_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
//------------------------------------------------------------------------------
// tb_bin2bcd_seq
//
// Self-checking bench for bin2bcd_seq with the default parameters. A table of
// directed vectors is run back-to-back, followed by hand-written sequences for
// start-while-busy, mid-conversion reset and continuously held start.
// The blank mask is checked only when BIN2BCD_BLANK_EN is defined.
//------------------------------------------------------------------------------
module tb_bin2bcd_seq;

    localparam int LATENCY = 16;

    logic        clk_50Mhz;
    logic        rst;
    logic        start;
    logic [15:0] bin_in;
    logic        busy;
    logic        done;
    logic [15:0] bcd_out;
    logic        overflow;
`ifdef BIN2BCD_BLANK_EN
    logic [3:0]  blank;
`endif

    int checks;
    int errors;

    typedef struct {
        logic [15:0] bin;
        logic [15:0] expBcd;
        logic        expOvf;
        logic [3:0]  expBlank;
    } vector_t;

    vector_t vectors[13];

    bin2bcd_seq #(
        .IN_W       (16),
        .DIGITS     (4),
        .INT_DIGITS (5)
    ) dut (
        .clk_50Mhz (clk_50Mhz),
        .rst       (rst),
        .start     (start),
        .bin_in    (bin_in),
        .busy      (busy),
        .done      (done),
        .bcd_out   (bcd_out),
        .overflow  (overflow)
`ifdef BIN2BCD_BLANK_EN
        ,
        .blank     (blank)
`endif
    );

    // 50 MHz clock.
    initial clk_50Mhz = 1'b0;
    always #10 clk_50Mhz = ~clk_50Mhz;

    // Global watchdog so the run can never hang.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Compare one value against its expected value and count the result.
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Present a start request for exactly one active edge. Called #1 after an
    // edge; returns #1 after the edge that sampled start.
    task automatic applyStimulus(input logic [15:0] value);
        start  = 1'b1;
        bin_in = value;
        @(posedge clk_50Mhz);
        #1;
        start  = 1'b0;
    endtask

    // Wait for done, counting edges after the start edge; -1 on timeout.
    task automatic waitDone(output int latency);
        latency = -1;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk_50Mhz);
            #1;
            if (done) begin
                latency = i;
                break;
            end
        end
    endtask

    initial begin
        int lat;
        int doneCount;
        int doneAt;
        int lastDone;
        int badGap;
        int consec;
        int busyLow;
        logic prevDone;
        logic [15:0] capturedBcd;

        checks = 0;
        errors = 0;

        // Directed vectors with hand-computed results.
        vectors[0]  = '{16'd0,     16'h0000, 1'b0, 4'b1110};
        vectors[1]  = '{16'd1234,  16'h1234, 1'b0, 4'b0000};
        vectors[2]  = '{16'd42,    16'h0042, 1'b0, 4'b1100};
        vectors[3]  = '{16'd9999,  16'h9999, 1'b0, 4'b0000};
        vectors[4]  = '{16'd10000, 16'h9999, 1'b1, 4'b0000};
        vectors[5]  = '{16'd65535, 16'h9999, 1'b1, 4'b0000};
        vectors[6]  = '{16'd7,     16'h0007, 1'b0, 4'b1110};
        vectors[7]  = '{16'd100,   16'h0100, 1'b0, 4'b1000};
        vectors[8]  = '{16'd1000,  16'h1000, 1'b0, 4'b0000};
        vectors[9]  = '{16'd909,   16'h0909, 1'b0, 4'b1000};
        vectors[10] = '{16'd10,    16'h0010, 1'b0, 4'b1100};
        vectors[11] = '{16'd59999, 16'h9999, 1'b1, 4'b0000};
        vectors[12] = '{16'd5,     16'h0005, 1'b0, 4'b1110};

        // Reset state.
        rst    = 1'b1;
        start  = 1'b0;
        bin_in = 16'd0;
        #5;
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_done", 32'(done), 32'd0);
        checkOutput("reset_bcd", 32'(bcd_out), 32'd0);
        checkOutput("reset_ovf", 32'(overflow), 32'd0);
`ifdef BIN2BCD_BLANK_EN
        checkOutput("reset_blank", 32'(blank), 32'd0);
`endif
        repeat (2) @(posedge clk_50Mhz);
        #1;
        rst = 1'b0;
        @(posedge clk_50Mhz);
        #1;

        // Table vectors, each started in the done cycle of the previous one.
        for (int v = 0; v < 13; v++) begin
            applyStimulus(vectors[v].bin);
            checkOutput($sformatf("vec%0d_busy", v), 32'(busy), 32'd1);
            checkOutput($sformatf("vec%0d_doneLow", v), 32'(done), 32'd0);
            waitDone(lat);
            checkOutput($sformatf("vec%0d_latency", v), 32'(lat), 32'(LATENCY));
            checkOutput($sformatf("vec%0d_bcd", v), 32'(bcd_out), 32'(vectors[v].expBcd));
            checkOutput($sformatf("vec%0d_ovf", v), 32'(overflow), 32'(vectors[v].expOvf));
            checkOutput($sformatf("vec%0d_busyAtDone", v), 32'(busy), 32'd0);
`ifdef BIN2BCD_BLANK_EN
            checkOutput($sformatf("vec%0d_blank", v), 32'(blank), 32'(vectors[v].expBlank));
`endif
        end

        // Outputs hold their value while idle.
        repeat (3) @(posedge clk_50Mhz);
        #1;
        checkOutput("hold_bcd", 32'(bcd_out), 32'h0005);
        checkOutput("hold_done", 32'(done), 32'd0);

        // Start with 500; a second start and bin_in change while busy must
        // have no effect.
        applyStimulus(16'd500);
        doneCount   = 0;
        doneAt      = -1;
        busyLow     = 0;
        capturedBcd = 16'h0;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk_50Mhz);
            #1;
            if (c == 4) begin
                start  = 1'b1;
                bin_in = 16'd7;
            end
            if (c == 5) begin
                start  = 1'b0;
                bin_in = 16'd1234;
            end
            if (c < LATENCY && !busy) busyLow++;
            if (done) begin
                doneCount++;
                doneAt      = c;
                capturedBcd = bcd_out;
            end
        end
        checkOutput("busyIgnore_doneCount", 32'(doneCount), 32'd1);
        checkOutput("busyIgnore_doneAt", 32'(doneAt), 32'(LATENCY));
        checkOutput("busyIgnore_bcd", 32'(capturedBcd), 32'h0500);
        checkOutput("busyIgnore_busyLow", 32'(busyLow), 32'd0);

        // Reset in the middle of a conversion of 321.
        applyStimulus(16'd321);
        repeat (7) @(posedge clk_50Mhz);
        #1;
        checkOutput("midReset_busyBefore", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        checkOutput("midReset_busy", 32'(busy), 32'd0);
        checkOutput("midReset_done", 32'(done), 32'd0);
        checkOutput("midReset_bcd", 32'(bcd_out), 32'd0);
        repeat (2) @(posedge clk_50Mhz);
        #1;
        rst = 1'b0;
        doneCount = 0;
        for (int c = 1; c <= 30; c++) begin
            @(posedge clk_50Mhz);
            #1;
            if (done || busy) doneCount++;
        end
        checkOutput("midReset_noActivity", 32'(doneCount), 32'd0);
        applyStimulus(16'd321);
        waitDone(lat);
        checkOutput("afterReset_latency", 32'(lat), 32'(LATENCY));
        checkOutput("afterReset_bcd", 32'(bcd_out), 32'h0321);
        checkOutput("afterReset_ovf", 32'(overflow), 32'd0);
`ifdef BIN2BCD_BLANK_EN
        checkOutput("afterReset_blank", 32'(blank), 32'b1000);
`endif

        // Start held high continuously with 77: done every 17 cycles.
        @(posedge clk_50Mhz);
        #1;
        start     = 1'b1;
        bin_in    = 16'd77;
        doneCount = 0;
        lastDone  = -1;
        badGap    = 0;
        consec    = 0;
        busyLow   = 0;
        prevDone  = 1'b0;
        for (int c = 1; c <= 60; c++) begin
            @(posedge clk_50Mhz);
            #1;
            if (done) begin
                doneCount++;
                if (prevDone) consec++;
                if (lastDone >= 0 && (c - lastDone) != LATENCY + 1) badGap++;
                if (lastDone < 0 && c != LATENCY + 1) badGap++;
                if (bcd_out !== 16'h0077) busyLow++;
                lastDone = c;
            end
            prevDone = done;
        end
        start = 1'b0;
        checkOutput("held_doneCount", 32'(doneCount), 32'd3);
        checkOutput("held_gap", 32'(badGap), 32'd0);
        checkOutput("held_consecutive", 32'(consec), 32'd0);
        checkOutput("held_bcdWrong", 32'(busyLow), 32'd0);

        // Drain the conversion still in flight.
        waitDone(lat);
        checkOutput("held_drain", 32'(lat > 0), 32'd1);
        checkOutput("held_finalBcd", 32'(bcd_out), 32'h0077);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
